// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared constants and parity helper for the gate1 IJTAG data TDR.
package firebird7_in_gate1_tessent_tdr_pkg;

  localparam int DATA_W  = 19;
  localparam int SEL_IDX = 0;

  function automatic logic tdr_parity(input logic [DATA_W:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_tdr_w19.sv
// IJTAG TDR driving the gate1 19-bit data mux: posedge capture/shift stage, negedge update stage.
// Optional frame parity check enabled by defining FIREBIRD7_IN_GATE1_TDR_PARITY_EN.
module firebird7_in_gate1_tessent_data_tdr_w19
  import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
  parameter int   WIDTH     = DATA_W,
  parameter logic SEL_RESET = 1'b0
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] capture_data_in,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  localparam int CHAIN_W = WIDTH + 2;
`else
  localparam int CHAIN_W = WIDTH + 1;
`endif

  logic [CHAIN_W-1:0] shift_reg;
  logic [CHAIN_W-1:0] capture_frame;
  logic               frame_ok;

  // Select bit sits at the LSB so it is the first bit out on readback.
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  assign capture_frame = {tdr_parity({capture_data_in, ijtag_select}), capture_data_in, ijtag_select};
  assign frame_ok      = (tdr_parity(shift_reg[WIDTH:0]) == shift_reg[WIDTH+1]);
`else
  assign capture_frame = {capture_data_in, ijtag_select};
  assign frame_ok      = 1'b1;
`endif

  // Capture has priority over shift when both enables are high.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      shift_reg <= '0;
    end else if (ijtag_sel && ijtag_ce) begin
      shift_reg <= capture_frame;
    end else if (ijtag_sel && ijtag_se) begin
      shift_reg <= {ijtag_si, shift_reg[CHAIN_W-1:1]};
    end
  end

  assign ijtag_so = shift_reg[0];

  // Negedge update keeps the mux controls stable throughout posedge shifting.
  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      ijtag_select   <= SEL_RESET;
      ijtag_data_out <= '0;
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
      parity_err     <= 1'b0;
`endif
    end else if (ijtag_sel && ijtag_ue) begin
      if (frame_ok) begin
        ijtag_select   <= shift_reg[SEL_IDX];
        ijtag_data_out <= shift_reg[WIDTH:1];
      end
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
      parity_err <= !frame_ok;
`endif
    end
  end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_tdr_w19.sv
// Self-checking bench for the gate1 data TDR; scan-out stream checked against a bit queue.
module tb_firebird7_in_gate1_tessent_data_tdr_w19;
  import firebird7_in_gate1_tessent_tdr_pkg::*;

  localparam int W = DATA_W;
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  localparam int CH = W + 2;
`else
  localparam int CH = W + 1;
`endif

  logic tck = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0;
  logic [W-1:0] cap = '0;
  logic so, select_o;
  logic [W-1:0] data_o;
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  logic perr;
`endif

  int cmp_count = 0;
  int err_count = 0;
  logic exp_q[$];
  logic [CH-1:0] fb;

  always #5 tck = ~tck;

  firebird7_in_gate1_tessent_data_tdr_w19 dut (
    .ijtag_tck       (tck),
    .ijtag_reset     (rst_n),
    .ijtag_sel       (sel),
    .ijtag_ce        (ce),
    .ijtag_se        (se),
    .ijtag_ue        (ue),
    .ijtag_si        (si),
    .ijtag_so        (so),
    .capture_data_in (cap),
    .ijtag_select    (select_o),
    .ijtag_data_out  (data_o)
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    ,
    .parity_err      (perr)
`endif
  );

  function automatic logic [CH-1:0] mk_frame(input logic s, input logic [W-1:0] d);
    logic [CH-1:0] f;
    f = '0;
    f[W:0] = {d, s};
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    f[CH-1] = ^{d, s};
`endif
    return f;
  endfunction

  // Inputs change just after negedge; outputs are sampled there too.
  task automatic tick();
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic shift_frame(input logic [CH-1:0] f);
    sel = 1'b1;
    se  = 1'b1;
    for (int i = 0; i < CH; i++) begin
      si = f[i];
      tick();
    end
    se = 1'b0;
    si = 1'b0;
  endtask

  task automatic pulse_ue();
    sel = 1'b1;
    ue  = 1'b1;
    tick();
    ue  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    cmp_count++;
    if (select_o !== 1'b0 || data_o !== '0 || so !== 1'b0) begin
      err_count++;
      $display("FAIL reset_state: select=%b data=%h so=%b, want 0/00000/0", select_o, data_o, so);
    end
    @(negedge tck);
    #1;
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_load();
    logic [CH-1:0] f;
    f = mk_frame(1'b1, 19'h5A5A5);
    sel = 1'b1;
    se  = 1'b1;
    for (int i = 0; i < CH; i++) begin
      si = f[i];
      tick();
      cmp_count++;
      if (select_o !== 1'b0 || data_o !== '0) begin
        err_count++;
        $display("FAIL load_hold[%0d]: select=%b data=%h, want 0/00000", i, select_o, data_o);
      end
    end
    se = 1'b0;
    pulse_ue();
    cmp_count++;
    if (select_o !== 1'b1 || data_o !== 19'h5A5A5) begin
      err_count++;
      $display("FAIL load_update: select=%b data=%h, want 1/5a5a5", select_o, data_o);
    end
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    cmp_count++;
    if (perr !== 1'b0) begin
      err_count++;
      $display("FAIL load_perr: parity_err=%b, want 0", perr);
    end
`endif
    $display("load: select=%b data=%h", select_o, data_o);
  endtask

  task automatic test_capture();
    logic [CH-1:0] fc, fa;
    logic b, got;
    fc = mk_frame(1'b1, 19'h7FFFF);
    fa = CH'($urandom);
    fb = mk_frame(1'b1, 19'($urandom));
    exp_q.delete();
    for (int i = 0; i < CH; i++) exp_q.push_back(fc[i]);
    cap = 19'h7FFFF;
    sel = 1'b1;
    ce  = 1'b1;
    tick();
    ce  = 1'b0;
    got = exp_q.pop_front();
    cmp_count++;
    if (so !== got) begin
      err_count++;
      $display("FAIL capture_so0: so=%b, want %b", so, got);
    end
    // Two full chain lengths: the captured frame then frame A wrap out, frame B stays loaded.
    se = 1'b1;
    for (int j = 0; j < 2 * CH; j++) begin
      b  = (j < CH) ? fa[j] : fb[j - CH];
      si = b;
      exp_q.push_back(b);
      tick();
      got = exp_q.pop_front();
      cmp_count++;
      if (so !== got) begin
        err_count++;
        $display("FAIL capture_stream[%0d]: so=%b, want %b", j + 1, so, got);
      end
    end
    se = 1'b0;
    si = 1'b0;
    $display("capture: readback of 7ffff streamed, frame %h left in chain", fb);
  endtask

  task automatic test_not_selected();
    sel = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ce = 1'($urandom);
      se = 1'($urandom);
      ue = 1'($urandom);
      si = 1'($urandom);
      tick();
      cmp_count++;
      if (so !== fb[0] || select_o !== 1'b1 || data_o !== 19'h5A5A5) begin
        err_count++;
        $display("FAIL unsel_hold[%0d]: so=%b select=%b data=%h, want %b/1/5a5a5",
                 i, so, select_o, data_o, fb[0]);
      end
    end
    ce = 1'b0;
    se = 1'b0;
    ue = 1'b0;
    si = 1'b0;
    pulse_ue();
    cmp_count++;
    if (select_o !== fb[0] || data_o !== fb[W:1]) begin
      err_count++;
      $display("FAIL unsel_contents: select=%b data=%h, want %b/%h", select_o, data_o, fb[0], fb[W:1]);
    end
    $display("not_selected: update applied select=%b data=%h", select_o, data_o);
  endtask

  task automatic test_ce_se();
    logic [CH-1:0] fe;
    logic got;
    shift_frame('0);
    fe = mk_frame(select_o, 19'h00001);
    exp_q.delete();
    for (int i = 0; i < CH; i++) exp_q.push_back(fe[i]);
    cap = 19'h00001;
    sel = 1'b1;
    ce  = 1'b1;
    se  = 1'b1;
    si  = 1'b1;
    tick();
    ce  = 1'b0;
    si  = 1'b0;
    for (int j = 0; j < CH; j++) begin
      got = exp_q.pop_front();
      cmp_count++;
      if (so !== got) begin
        err_count++;
        $display("FAIL ce_se_bit[%0d]: so=%b, want %b", j, so, got);
      end
      if (j < CH - 1) tick();
    end
    se = 1'b0;
    $display("ce_se: capture took priority, frame %h", fe);
  endtask

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  task automatic test_parity();
    logic [CH-1:0] bad, good;
    logic          prev_sel;
    logic [W-1:0]  prev_data;
    prev_sel  = select_o;
    prev_data = data_o;
    good = mk_frame(1'b0, 19'h12345);
    bad  = good;
    bad[CH-1] = ~bad[CH-1];
    shift_frame(bad);
    pulse_ue();
    cmp_count++;
    if (select_o !== prev_sel || data_o !== prev_data || perr !== 1'b1) begin
      err_count++;
      $display("FAIL parity_bad: select=%b data=%h perr=%b, want %b/%h/1",
               select_o, data_o, perr, prev_sel, prev_data);
    end
    shift_frame(good);
    pulse_ue();
    cmp_count++;
    if (select_o !== 1'b0 || data_o !== 19'h12345 || perr !== 1'b0) begin
      err_count++;
      $display("FAIL parity_good: select=%b data=%h perr=%b, want 0/12345/0", select_o, data_o, perr);
    end
    $display("parity: bad frame rejected, good frame applied");
  endtask
`endif

  task automatic test_reset_mid();
    shift_frame(mk_frame(1'b1, '1));
    pulse_ue();
    cmp_count++;
    if (select_o !== 1'b1 || data_o !== 19'h7FFFF) begin
      err_count++;
      $display("FAIL premid_load: select=%b data=%h, want 1/7ffff", select_o, data_o);
    end
    sel = 1'b1;
    se  = 1'b1;
    si  = 1'b1;
    @(posedge tck);
    #2;
    rst_n = 1'b0;
    #1;
    cmp_count++;
    if (select_o !== 1'b0 || data_o !== '0 || so !== 1'b0) begin
      err_count++;
      $display("FAIL reset_mid: select=%b data=%h so=%b, want 0/00000/0", select_o, data_o, so);
    end
    @(negedge tck);
    #1;
    se = 1'b0;
    si = 1'b0;
    rst_n = 1'b1;
    tick();
    cmp_count++;
    if (select_o !== 1'b0 || data_o !== '0 || so !== 1'b0) begin
      err_count++;
      $display("FAIL reset_mid_after: select=%b data=%h so=%b, want 0/00000/0", select_o, data_o, so);
    end
    $display("reset_mid: both stages cleared");
  endtask

  initial begin
    test_reset();
    test_load();
    test_capture();
    test_not_selected();
    test_ce_se();
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
